// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: controller state encoding
// and the default operand width.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider_ctrl.sv
// Divider sequencer: IDLE/RUN/DONE state machine and iteration counter,
// producing load, shift and finish strobes for the datapath.
module divider_ctrl
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic Reset,
  input  logic start,
  input  logic div_zero,
  output logic load,
  output logic shift,
  output logic finish,
  output logic busy,
  output logic done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last;

  assign last = (cnt_q == CW'(WIDTH - 1));

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          cnt_d  = '0;
          // A zero divisor skips the iterations and reports straight away.
          finish = div_zero;
          state_d = div_zero ? DONE : RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (last) begin
          finish  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/divider_core.sv
// Unsigned restoring shift-subtract divider: one quotient bit per RUN cycle,
// results registered separately so they hold steady while iterating.
module divider_core
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic                 load, shift, finish, div_zero;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [WIDTH-1:0]     quot_q, quot_d, rem_q, rem_d;
  logic [2*WIDTH-1:0]   rq_q, rq_d, rq_step;
  logic                 dbz_q, dbz_d;
  logic [WIDTH:0]       r_shift, diff;

  assign div_zero = (divisor == '0);

  divider_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .Reset    (Reset),
    .start    (start),
    .div_zero (div_zero),
    .load     (load),
    .shift    (shift),
    .finish   (finish),
    .busy     (busy),
    .done     (done)
  );

  // The shifted partial remainder keeps its carry-out bit: 2R+1 can exceed
  // WIDTH bits whenever the divisor has its top bit set.
  always_comb begin
    r_shift = rq_q[2*WIDTH-1:WIDTH-1];
    diff    = r_shift - {1'b0, divisor_q};
    if (!diff[WIDTH]) begin
      rq_step = {diff[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b1};
    end else begin
      rq_step = {r_shift[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    rq_d      = rq_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    if (load) begin
      rq_d      = {{WIDTH{1'b0}}, dividend};
      divisor_d = divisor;
      dbz_d     = 1'b0;
    end else if (shift) begin
      rq_d = rq_step;
    end
    if (finish) begin
      if (load) begin
        quot_d = '1;
        rem_d  = dividend;
        dbz_d  = 1'b1;
      end else begin
        quot_d = rq_step[WIDTH-1:0];
        rem_d  = rq_step[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rq_q      <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      rq_q      <= rq_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_core.sv
// Directed bench for divider_core: expected results are queued at start and
// compared, with latency, when done pulses.
module tb_divider_core;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         Reset, start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, div_by_zero;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   k_q = 0;

  divider_core #(.WIDTH(W)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it);
    exp_t e;
    @(negedge clk);
    k_q      = cyc;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (expect_it) begin
      e.q   = (b == '0) ? '1 : a / b;
      e.r   = (b == '0) ? a : a % b;
      e.dbz = (b == '0);
      e.lat = (b == '0) ? 1 : W + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   guard = 0;
    while (done !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check({tag, "_done"}, done, 1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, cyc - k_q, e.lat);
      check({tag, "_quotient"}, quotient, e.q);
      check({tag, "_remainder"}, remainder, e.r);
      check({tag, "_dbz"}, div_by_zero, e.dbz);
      check({tag, "_busy"}, busy, 1);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_hold_q"}, quotient, e.q);
    end
  endtask

  initial begin
    Reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    Reset = 1'b1;

    start_op(32'd100, 32'd7, 1'b1);
    wait_done("div_100_7");
    start_op(32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_done("div_max_1");
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_max_max");
    start_op(32'd3, 32'd10, 1'b1);
    wait_done("div_3_10");
    start_op(32'd5, 32'd0, 1'b1);
    wait_done("div_by_0");

    repeat (3) @(negedge clk);
    check("idle_hold_q", quotient, 32'hFFFF_FFFF);
    check("idle_hold_r", remainder, 32'd5);
    check("idle_hold_dbz", div_by_zero, 1);

    // Second start arrives mid-RUN and must be dropped.
    start_op(32'd100, 32'd7, 1'b1);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("run_busy", busy, 1);
    check("run_hold_q", quotient, 32'hFFFF_FFFF);
    check("run_dbz_clear", div_by_zero, 0);
    wait_done("busy_start");

    // Reset in the middle of an iteration, then a clean division.
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    Reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    @(negedge clk);
    Reset = 1'b1;
    start_op(32'd9, 32'd2, 1'b1);
    wait_done("after_rst");

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_core.md
DIVIDER_CORE -- requirements
Module: divider_core

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-003 Port Reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port start, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-005 Port dividend, input, WIDTH bits: unsigned dividend, captured on the accepted start edge.
REQ-006 Port divisor, input, WIDTH bits: unsigned divisor, captured on the accepted start edge.
REQ-007 Port busy, output, 1 bit: high in RUN and DONE.
REQ-008 Port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 Port quotient, output, WIDTH bits: unsigned quotient.
REQ-010 Port remainder, output, WIDTH bits: unsigned remainder.
REQ-011 Port div_by_zero, output, 1 bit: set when the captured divisor is 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL latch both operands and clear div_by_zero.
- Divisor != 0: the next state SHALL be RUN with the iteration counter at 0.
- Divisor == 0: the next state SHALL be DONE.
REQ-014 The datapath SHALL be a restoring shift-subtract divider.
- It SHALL use a 2*WIDTH working register {R,Q}, initialised to {0,dividend}.
- Each RUN cycle SHALL shift {R,Q} left by 1 and compute a (WIDTH+1)-bit difference, R_shifted minus divisor.
- If the difference is non-negative, R SHALL take the difference and Q[0] SHALL be set to 1.
- Otherwise R SHALL be restored and Q[0] SHALL be 0.
REQ-015 RUN SHALL last exactly WIDTH cycles; the counter SHALL be $clog2(WIDTH) bits; RUN SHALL go to DONE when the counter reaches WIDTH-1.
REQ-016 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-017 Latency: with start accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH+1 (edge k+33 for WIDTH=32).
- For a zero divisor, done SHALL be high after edge k+1.
REQ-018 In DONE, quotient and remainder SHALL present the final Q and R.
- For a zero divisor: quotient SHALL be all ones, remainder SHALL equal the dividend, and div_by_zero SHALL be 1.
REQ-019 quotient, remainder and div_by_zero SHALL hold their values in IDLE until the next accepted start.
- They SHALL not change during RUN; the working register is internal.
REQ-020 start while busy=1 SHALL be ignored and SHALL not alter the operands or the state.
REQ-021 start high in the DONE cycle SHALL be ignored; a new start is accepted only in the following IDLE cycle or later.
REQ-022 Operand inputs SHALL be don't-care except on the accepted start edge.

Reset
REQ-023 Reset=0 SHALL, asynchronously and in any state including mid-RUN, force:
- state to IDLE and the counter to 0;
- busy, done and div_by_zero to 0;
- quotient, remainder and the working register to 0.
REQ-024 After Reset deasserts, the first start SHALL be accepted normally, with no residue from any aborted operation.

Structure
REQ-025 A shared package divider_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-026 The FSM and counter SHALL sit in one sub-module, divider_ctrl, which drives the load, shift and finish strobes to the datapath held in divider_core.

Verification
REQ-027 Normal division, WIDTH=32: dividend=100, divisor=7 -> done after edge k+33 with quotient=14, remainder=2, div_by_zero=0.
REQ-028 Maximum dividend: dividend=32'hFFFF_FFFF, divisor=1 -> quotient=32'hFFFF_FFFF, remainder=0.
- Also dividend=32'hFFFF_FFFF, divisor=32'hFFFF_FFFF -> quotient=1, remainder=0.
REQ-029 Small dividend: dividend=3, divisor=10 -> quotient=0, remainder=3.
REQ-030 Zero divisor: dividend=5, divisor=0 -> done after edge k+1, div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=5.
REQ-031 Busy start: a second start with 50/5 at RUN cycle 4 -> ignored; the first result is still 100/7 -> 14 rem 2.
REQ-032 Reset mid-RUN: Reset=0 at RUN cycle 10 -> immediately busy=0, done=0, quotient=0, remainder=0.
- A following 9/2 -> quotient=4, remainder=1 after 33 cycles.
